alu_frame_rx: RTL and testbench

ALU_FRAME_RX -- requirements
Module: alu_frame_rx

---
 rtl/alu_frame_rx.sv | 214 +++++++++++++++++++++
 tb/tb_alu_frame_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_frame_rx.sv
// -----------------------------------------------------------------------------
// alu_frame_rx
//
// Serial frame receiver for a small ALU command link. The line idles high and
// carries 11-bit words, one bit per clk, MSB first:
//   start(0), type, payload[7:0], stop(1)
// Data words (type 0) shift their payload byte into a 64-bit register {b,a}.
// A command word (type 1) carries {1'b0, op[2:0], crc[3:0]} and closes a
// frame. The frame is accepted only if exactly eight data words preceded it,
// the CRC-4 over {b, a, 1'b1, op} matches, and op is a supported operation.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   sin        in   1   serial input, idle high
//   a          out  32  operand A of the last accepted frame
//   b          out  32  operand B of the last accepted frame
//   op         out  3   opcode of the last accepted frame
//   valid      out  1   one-cycle pulse: frame accepted
//   err_data   out  1   one-cycle pulse: data word count was not eight
//   err_crc    out  1   one-cycle pulse: CRC mismatch
//   err_op     out  1   one-cycle pulse: unsupported opcode
//   err_frame  out  1   one-cycle pulse: bad stop bit or malformed command
// -----------------------------------------------------------------------------
module alu_frame_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        sin,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op,
  output logic        valid,
  output logic        err_data,
  output logic        err_crc,
  output logic        err_op,
  output logic        err_frame
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TYPE    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_STOP    = 2'd3
  } state_t;

  localparam logic [3:0] WCNT_FULL = 4'd8;
  localparam logic [3:0] WCNT_SAT  = 4'd9;

  // CRC-4, polynomial x^4+x+1, initial 0, no final XOR, message MSB first.
  function automatic logic [3:0] crc4(input logic [67:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'd0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    end
    return c;
  endfunction

  // Supported operations: AND, OR, ADD, SUB.
  function automatic logic op_legal(input logic [2:0] o);
    return (o == 3'b000) || (o == 3'b001) || (o == 3'b100) || (o == 3'b101);
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        type_q, type_d;
  logic [7:0]  pay_q, pay_d;
  logic [63:0] shreg_q, shreg_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        need_high_q, need_high_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        valid_q, valid_d;
  logic        err_data_q, err_data_d;
  logic        err_crc_q, err_crc_d;
  logic        err_op_q, err_op_d;
  logic        err_frame_q, err_frame_d;

  logic [3:0]  crc_calc;

  // CRC of the current register contents with the command's opcode; only
  // meaningful while the stop bit of a command word is being sampled.
  assign crc_calc = crc4({shreg_q, 1'b1, pay_q[6:4]});

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= 3'd0;
      type_q      <= 1'b0;
      pay_q       <= 8'd0;
      shreg_q     <= 64'd0;
      wcnt_q      <= 4'd0;
      need_high_q <= 1'b0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      op_q        <= 3'd0;
      valid_q     <= 1'b0;
      err_data_q  <= 1'b0;
      err_crc_q   <= 1'b0;
      err_op_q    <= 1'b0;
      err_frame_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      type_q      <= type_d;
      pay_q       <= pay_d;
      shreg_q     <= shreg_d;
      wcnt_q      <= wcnt_d;
      need_high_q <= need_high_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      valid_q     <= valid_d;
      err_data_q  <= err_data_d;
      err_crc_q   <= err_crc_d;
      err_op_q    <= err_op_d;
      err_frame_q <= err_frame_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      // After a framing error the line must be seen high before a new start.
      S_IDLE:    if (!need_high_q && !sin) state_d = S_TYPE;
      S_TYPE:    state_d = S_PAYLOAD;
      S_PAYLOAD: if (bitcnt_q == 3'd7) state_d = S_STOP;
      S_STOP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and output-pulse logic.
  always_comb begin
    bitcnt_d    = bitcnt_q;
    type_d      = type_q;
    pay_d       = pay_q;
    shreg_d     = shreg_q;
    wcnt_d      = wcnt_q;
    need_high_d = need_high_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    valid_d     = 1'b0;
    err_data_d  = 1'b0;
    err_crc_d   = 1'b0;
    err_op_d    = 1'b0;
    err_frame_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sin) need_high_d = 1'b0;
      end

      S_TYPE: begin
        type_d   = sin;
        bitcnt_d = 3'd0;
      end

      S_PAYLOAD: begin
        pay_d    = {pay_q[6:0], sin};
        bitcnt_d = bitcnt_q + 3'd1;
      end

      S_STOP: begin
        bitcnt_d = 3'd0;
        if (!sin) begin
          // Broken stop bit: drop the frame collected so far.
          err_frame_d = 1'b1;
          wcnt_d      = 4'd0;
          need_high_d = 1'b1;
        end else if (!type_q) begin
          // Older bytes fall off the top, so the register keeps the last 8.
          shreg_d = {shreg_q[55:0], pay_q};
          wcnt_d  = (wcnt_q == WCNT_SAT) ? WCNT_SAT : (wcnt_q + 4'd1);
        end else if (pay_q[7]) begin
          err_frame_d = 1'b1;
          wcnt_d      = 4'd0;
        end else begin
          wcnt_d = 4'd0;
          if (wcnt_q != WCNT_FULL) begin
            err_data_d = 1'b1;
          end else if (crc_calc != pay_q[3:0]) begin
            err_crc_d = 1'b1;
          end else if (!op_legal(pay_q[6:4])) begin
            err_op_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            b_d     = shreg_q[63:32];
            a_d     = shreg_q[31:0];
            op_d    = pay_q[6:4];
          end
        end
      end

      default: ;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign op        = op_q;
  assign valid     = valid_q;
  assign err_data  = err_data_q;
  assign err_crc   = err_crc_q;
  assign err_op    = err_op_q;
  assign err_frame = err_frame_q;

endmodule

// File: tb/tb_alu_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_alu_frame_rx
//
// Bench for alu_frame_rx. Stimulus is built word by word; a word-level model
// tracks what the receiver must report after each stop bit, and a compare
// process checks every output on every falling clock edge. Directed scenarios
// add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_alu_frame_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        valid, err_data, err_crc, err_op, err_frame;

  alu_frame_rx dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .a         (a),
    .b         (b),
    .op        (op),
    .valid     (valid),
    .err_data  (err_data),
    .err_crc   (err_crc),
    .err_op    (err_op),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state.
  logic [63:0] m_sh;
  int          m_cnt;
  logic [31:0] ea, eb;
  logic [2:0]  eop;
  logic        ev, ed, ec, eo, ef;
  bit          chk_en = 1'b0;

  task automatic check1(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC-4 (x^4+x+1) as the remainder of polynomial long division of msg*x^4.
  function automatic logic [3:0] crc_ref(input logic [67:0] msg);
    logic [71:0] r;
    r = {msg, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic op_ok(input logic [2:0] o);
    return o inside {3'b000, 3'b001, 3'b100, 3'b101};
  endfunction

  task automatic model_reset();
    m_sh = '0; m_cnt = 0; ea = '0; eb = '0; eop = '0;
    {ev, ed, ec, eo, ef} = '0;
  endtask

  // One line bit; the model's pulse expectations expire at every edge.
  task automatic tick(input logic bv);
    sin = bv;
    @(posedge clk);
    #1;
    {ev, ed, ec, eo, ef} = '0;
    if (rst) model_reset();
  endtask

  // Word-level rules, applied once the stop bit has been sampled.
  task automatic model_word(input logic t, input logic [7:0] p, input logic s);
    if (!s) begin
      ef = 1'b1; m_cnt = 0;
    end else if (!t) begin
      m_sh  = {m_sh[55:0], p};
      m_cnt = (m_cnt >= 9) ? 9 : m_cnt + 1;
    end else if (p[7]) begin
      ef = 1'b1; m_cnt = 0;
    end else begin
      if (m_cnt != 8)                                   ed = 1'b1;
      else if (crc_ref({m_sh, 1'b1, p[6:4]}) != p[3:0]) ec = 1'b1;
      else if (!op_ok(p[6:4]))                          eo = 1'b1;
      else begin
        ev = 1'b1; eb = m_sh[63:32]; ea = m_sh[31:0]; eop = p[6:4];
      end
      m_cnt = 0;
    end
  endtask

  task automatic send_word(input logic t, input logic [7:0] p, input logic s);
    tick(1'b0);
    tick(t);
    for (int i = 7; i >= 0; i--) tick(p[i]);
    tick(s);
    model_word(t, p, s);
  endtask

  task automatic send_data(input logic [7:0] d);
    send_word(1'b0, d, 1'b1);
  endtask

  task automatic send_cmd(input logic [2:0] o, input logic [3:0] c);
    send_word(1'b1, {1'b0, o, c}, 1'b1);
  endtask

  task automatic send_bytes(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_data(v[63 - 8*i -: 8]);
  endtask

  // Literal check of the pulse vector {valid,err_data,err_crc,err_op,err_frame}
  // in the cycle after a stop bit.
  task automatic lit_pulses(input string name, input logic [4:0] exp);
    @(negedge clk);
    check1(name, {27'd0, valid, err_data, err_crc, err_op, err_frame},
           {27'd0, exp});
  endtask

  // Every output against the model, every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("valid",     {31'd0, valid},     {31'd0, ev});
      check1("err_data",  {31'd0, err_data},  {31'd0, ed});
      check1("err_crc",   {31'd0, err_crc},   {31'd0, ec});
      check1("err_op",    {31'd0, err_op},    {31'd0, eo});
      check1("err_frame", {31'd0, err_frame}, {31'd0, ef});
      check1("a",  a, ea);
      check1("b",  b, eb);
      check1("op", {29'd0, op}, {29'd0, eop});
    end
  end

  logic [63:0] s2;
  logic [3:0]  c_op2;

  initial begin
    s2  = 64'h0000_0002_0000_0001;
    sin = 1'b1;
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
    rst = 1'b0;
    tick(1'b1);

    // Model pins against hand-computed CRCs.
    check1("crc_zero_and", {28'd0, crc_ref({64'd0, 1'b1, 3'b000})}, 32'hB);
    check1("crc_s2_add",   {28'd0, crc_ref({s2, 1'b1, 3'b100})},    32'hC);

    // Scenario 1: eight zero bytes, AND, crc B.
    send_bytes(64'd0, 8);
    send_cmd(3'b000, 4'hB);
    lit_pulses("s1_pulses", 5'b10000);

    // Scenario 2: ADD with b=2, a=1 (back-to-back words, no idle gap).
    send_bytes(s2, 8);
    send_cmd(3'b100, 4'hC);
    lit_pulses("s2_pulses", 5'b10000);
    check1("s2_b", b, 32'h2);
    check1("s2_a", a, 32'h1);
    check1("s2_op", {29'd0, op}, 32'h4);
    tick(1'b1);

    // Scenario 3: seven words, then nine words; operands must hold.
    send_bytes(64'h1122_3344_5566_7788, 7);
    send_cmd(3'b100, crc_ref({m_sh, 1'b1, 3'b100}));
    lit_pulses("s3_seven", 5'b01000);
    send_bytes(64'hAABB_CCDD_EEFF_0102, 8);
    send_data(8'h03);
    send_cmd(3'b100, crc_ref({m_sh, 1'b1, 3'b100}));
    lit_pulses("s3_nine", 5'b01000);
    check1("s3_b_hold", b, 32'h2);
    check1("s3_a_hold", a, 32'h1);

    // Zero data words before a command.
    send_cmd(3'b000, 4'hB);
    lit_pulses("no_data", 5'b01000);

    // Scenario 4: bad CRC, then unsupported op with its correct CRC.
    send_bytes(64'd0, 8);
    send_cmd(3'b000, 4'hA);
    lit_pulses("s4_crc", 5'b00100);
    send_bytes(64'd0, 8);
    c_op2 = crc_ref({64'd0, 1'b1, 3'b010});
    send_cmd(3'b010, c_op2);
    lit_pulses("s4_op", 5'b00010);

    // Command with payload bit 7 set.
    send_bytes(64'd0, 8);
    send_word(1'b1, 8'h8B, 1'b1);
    lit_pulses("cmd_bit7", 5'b00001);
    tick(1'b1);

    // Scenario 5: broken stop bit, line held low (no restart), then a frame.
    send_bytes(64'd0, 3);
    send_word(1'b0, 8'h5A, 1'b0);
    lit_pulses("s5_frame", 5'b00001);
    for (int i = 0; i < 3; i++) tick(1'b0);
    tick(1'b1);
    send_bytes(s2, 8);
    send_cmd(3'b100, 4'hC);
    lit_pulses("s5_valid", 5'b10000);

    // Scenario 6: reset inside the 4th data word, then the Scenario 2 frame.
    send_bytes(64'h0102_0304_0506_0708, 3);
    tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'($urandom_range(0, 1)));
    check1("s6_rst_a", a, 32'h0);
    check1("s6_rst_b", b, 32'h0);
    rst = 1'b0;
    tick(1'b1);
    send_bytes(s2, 8);
    send_cmd(3'b100, 4'hC);
    lit_pulses("s6_valid", 5'b10000);
    check1("s6_b", b, 32'h2);
    check1("s6_a", a, 32'h1);
    tick(1'b1);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      int          nd;
      logic [2:0]  o;
      logic [3:0]  c;
      logic        b7, st;
      nd = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(0, 10));
      for (int w = 0; w < nd; w++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick(1'b1);
        if ($urandom_range(0, 24) == 0) begin
          send_word(1'b0, 8'($urandom), 1'b0);
          tick(1'b1);
        end else begin
          send_data(8'($urandom));
        end
      end
      o  = 3'($urandom);
      c  = ($urandom_range(0, 3) != 0) ? crc_ref({m_sh, 1'b1, o}) : 4'($urandom);
      b7 = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 11) != 0);
      send_word(1'b1, {b7, o, c}, st);
      tick(1'b1);
      if ($urandom_range(0, 1) == 1) tick(1'b1);
    end

    for (int i = 0; i < 4; i++) tick(1'b1);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
